// File: rtl/cpu_pkg.sv
//------------------------------------------------------------------------------
// cpu_pkg: opcode encodings, instruction field positions, fetch FSM states
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_NOT = 4'b0011;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_LDI = 4'b0111;
   localparam logic [3:0] OP_LD  = 4'b1000;
   localparam logic [3:0] OP_SD  = 4'b1010;
   localparam logic [3:0] OP_BNE = 4'b1110;
   localparam logic [3:0] OP_JMP = 4'b1111;

   localparam int OPC_HI = 31;
   localparam int OPC_LO = 28;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_ISSUE = 2'd2
   } fetch_state_t;

   function automatic logic is_legal_opcode(input logic [3:0] op);
      case (op)
         OP_AND, OP_OR, OP_ADD, OP_NOT, OP_SUB,
         OP_LDI, OP_LD, OP_SD, OP_BNE, OP_JMP: is_legal_opcode = 1'b1;
         default:                              is_legal_opcode = 1'b0;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
//------------------------------------------------------------------------------
// instr_fetch_unit_if: imem request bus, redirect/stall controls, issue bus
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface instr_fetch_unit_if #(
   parameter int PC_W = 32
);
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_ready;
   logic [31:0]     imem_rdata;
   logic            redirect_valid;
   logic [PC_W-1:0] redirect_pc;
   logic            stall;
   logic            instr_valid;
   logic [31:0]     instr;
   logic [3:0]      Opcode;
   logic [PC_W-1:0] instr_pc;
   logic            illegal_op;

   // master: the fetch unit; slave: memory plus downstream pipeline
   modport master (
      output imem_req, imem_addr, instr_valid, instr, Opcode, instr_pc, illegal_op,
      input  imem_ready, imem_rdata, redirect_valid, redirect_pc, stall
   );

   modport slave (
      input  imem_req, imem_addr, instr_valid, instr, Opcode, instr_pc, illegal_op,
      output imem_ready, imem_rdata, redirect_valid, redirect_pc, stall
   );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
//------------------------------------------------------------------------------
// instr_fetch_unit: PC owner, imem fetch FSM, redirect handling, issue to decode
// Optional feature macro: ILLEGAL_OP_TRAP_EN (trap illegal opcodes to TRAP_VEC)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module instr_fetch_unit
   import cpu_pkg::*;
#(
   parameter int              PC_W     = 32,
   parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}},
   parameter logic [PC_W-1:0] TRAP_VEC = PC_W'('h100)
) (
   input  logic               clk,
   input  logic               rst_n,
   instr_fetch_unit_if.master bus
);

`ifdef ILLEGAL_OP_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   localparam logic [PC_W-1:0] WORD_MASK = ~{{(PC_W-2){1'b0}}, 2'b11};

   fetch_state_t    state;
   logic [PC_W-1:0] pc;
   logic            req;
   logic            valid;
   logic [31:0]     instr_q;
   logic [PC_W-1:0] instr_pc_q;
   logic            illegal_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         pc         <= RESET_PC;
         req        <= 1'b0;
         valid      <= 1'b0;
         instr_q    <= 32'd0;
         instr_pc_q <= '0;
         illegal_q  <= 1'b0;
      end else begin
         illegal_q <= 1'b0;
         // Redirect overrides whatever the FSM would do, including a completing fetch
         if (bus.redirect_valid) begin
            pc    <= bus.redirect_pc & WORD_MASK;
            valid <= 1'b0;
            req   <= 1'b1;
            state <= S_FETCH;
         end else begin
            case (state)
               S_IDLE: begin
                  req   <= 1'b1;
                  state <= S_FETCH;
               end
               S_FETCH: begin
                  if (bus.imem_ready) begin
                     if (TRAP_EN && !is_legal_opcode(bus.imem_rdata[OPC_HI:OPC_LO])) begin
                        illegal_q <= 1'b1;
                        pc        <= TRAP_VEC;
                     end else begin
                        instr_q    <= bus.imem_rdata;
                        instr_pc_q <= pc;
                        valid      <= 1'b1;
                        req        <= 1'b0;
                        state      <= S_ISSUE;
                     end
                  end
               end
               S_ISSUE: begin
                  if (!bus.stall) begin
                     pc    <= pc + PC_W'(4);
                     valid <= 1'b0;
                     req   <= 1'b1;
                     state <= S_FETCH;
                  end
               end
               default: begin
                  req   <= 1'b0;
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign bus.imem_req    = req;
   assign bus.imem_addr   = pc;
   assign bus.instr_valid = valid;
   assign bus.instr       = instr_q;
   assign bus.Opcode      = instr_q[OPC_HI:OPC_LO];
   assign bus.instr_pc    = instr_pc_q;
   assign bus.illegal_op  = illegal_q;

endmodule

`default_nettype wire
